// File: rtl/dled_scan.sv
// rtl/dled_scan.sv - multi-digit 7-segment scanner with sequential binary-to-BCD conversion
// Optional blink gating is compiled in when DLED_SCAN_BLINK_EN is defined.
module dled_scan #(
  parameter int DIGITS   = 3,
  parameter int VAL_W    = 8,
  parameter int SCAN_DIV = 24000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VAL_W-1:0]  val,
  input  logic              val_vld,
`ifdef DLED_SCAN_BLINK_EN
  input  logic              blink,
`endif
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] sel,
  output logic [6:0]        seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(VAL_W + 1);

  // 10^n in 64 bits; the overflow limit for the digit count
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  // standard {a,b,c,d,e,f,g} table; non-decimal nibbles stay dark
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t             state;
  logic [VAL_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   shift_cnt;
  logic               ovf_pend;
  logic [BCD_W-1:0]   disp_buf;
  logic [63:0]        val_ext;

  logic [PS_W-1:0]    presc;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic               tick;
  logic [DIGITS-1:0]  blank_vec;
  logic               upper_zero;
  logic [3:0]         nib;
  logic               nib_blank;
  logic [DIGITS-1:0]  sel_next;
  logic [6:0]         seg_next;

  assign val_ext = 64'(val);

  // add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

  // conversion FSM: capture, VAL_W shift-add-3 steps, atomic commit to the display buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      bin_sr    <= '0;
      bcd_acc   <= '0;
      shift_cnt <= '0;
      ovf_pend  <= 1'b0;
      disp_buf  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (val_vld) begin
            bin_sr    <= val;
            bcd_acc   <= '0;
            shift_cnt <= '0;
            ovf_pend  <= (val_ext >= OVF_LIMIT);
            busy      <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd_acc, bin_sr} <= {bcd_adj, bin_sr} << 1;
          if (shift_cnt == CNT_W'(VAL_W - 1)) begin
            state <= S_COMMIT;
          end else begin
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end
        S_COMMIT: begin
          disp_buf <= bcd_acc;
          ovf      <= ovf_pend;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tick     = (presc == PS_W'(SCAN_DIV - 1));
  assign idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);

  // a digit is blanked when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (disp_buf[4*i +: 4] == 4'd0);
      blank_vec[i] = upper_zero & (i != 0);
    end
  end

`ifdef DLED_SCAN_BLINK_EN
  localparam int BLK_TICKS = 256 * DIGITS;
  localparam int BLK_W     = $clog2(BLK_TICKS);

  logic [BLK_W-1:0] blk_cnt;
  logic             blk_phase;

  // blink phase flips after every 256 complete scan cycles, counted in digit slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt   <= '0;
      blk_phase <= 1'b0;
    end else if (tick) begin
      if (blk_cnt == BLK_W'(BLK_TICKS - 1)) begin
        blk_cnt   <= '0;
        blk_phase <= ~blk_phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end
`endif

  // pattern for the digit that the next tick will select
  always_comb begin
    nib       = 4'd0;
    nib_blank = 1'b0;
    sel_next  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        nib         = disp_buf[4*i +: 4];
        nib_blank   = blank_vec[i];
        sel_next[i] = 1'b1;
      end
    end
    if (ovf) begin
      seg_next = 7'b0000001;
    end else if (nib_blank) begin
      seg_next = 7'b0000000;
    end else begin
      seg_next = seg_decode(nib);
    end
`ifdef DLED_SCAN_BLINK_EN
    if (blink && blk_phase) seg_next = 7'b0000000;
`endif
  end

  // slot prescaler and digit scan; sel and seg always move together on the tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= IDX_W'(DIGITS - 1);
      sel   <= '0;
      seg   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx_next;
      sel   <= sel_next;
      seg   <= seg_next;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

endmodule

// File: tb/tb_dled_scan.sv
// tb/tb_dled_scan.sv - scoreboard bench for dled_scan (3-digit and 2-digit instances)
module tb_dled_scan;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] val3, val2;
  logic       vld3, vld2;
  logic       busy3, ovf3, busy2, ovf2;
  logic [2:0] sel3;
  logic [1:0] sel2;
  logic [6:0] seg3, seg2;
`ifdef DLED_SCAN_BLINK_EN
  logic       blink = 1'b0;
`endif

  always #5 clk = ~clk;

  dled_scan #(.DIGITS(3), .VAL_W(8), .SCAN_DIV(SD)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .val     (val3),
    .val_vld (vld3),
`ifdef DLED_SCAN_BLINK_EN
    .blink   (blink),
`endif
    .busy    (busy3),
    .ovf     (ovf3),
    .sel     (sel3),
    .seg     (seg3)
  );

  dled_scan #(.DIGITS(2), .VAL_W(8), .SCAN_DIV(SD)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .val     (val2),
    .val_vld (vld2),
`ifdef DLED_SCAN_BLINK_EN
    .blink   (blink),
`endif
    .busy    (busy2),
    .ovf     (ovf2),
    .sel     (sel2),
    .seg     (seg2)
  );

  typedef struct {
    int          d;
    int          v;
    logic        ovf;
    logic [20:0] segs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input int n);
    case (n)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t make_exp(input int d, input int v);
    exp_t e;
    int   p;
    e.d    = d;
    e.v    = v;
    e.ovf  = (v >= ((d == 3) ? 1000 : 100));
    e.segs = '0;
    p      = 1;
    for (int i = 0; i < d; i++) begin
      if (e.ovf)              e.segs[7*i +: 7] = 7'b0000001;
      else if (i > 0 && v < p) e.segs[7*i +: 7] = 7'b0000000;
      else                    e.segs[7*i +: 7] = seg7((v / p) % 10);
      p = p * 10;
    end
    return e;
  endfunction

  function automatic logic [2:0] get_sel(input int d);
    return (d == 3) ? sel3 : {1'b0, sel2};
  endfunction
  function automatic logic [6:0] get_seg(input int d);
    return (d == 3) ? seg3 : seg2;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 3) ? busy3 : busy2;
  endfunction
  function automatic logic get_ovf(input int d);
    return (d == 3) ? ovf3 : ovf2;
  endfunction

  task automatic drive(input int d, input logic vld, input logic [7:0] v);
    if (d == 3) begin
      vld3 = vld;
      val3 = v;
    end else begin
      vld2 = vld;
      val2 = v;
    end
  endtask

  // pop the oldest expectation and compare 2*d scan slots against it
  task automatic scan_check();
    exp_t       e;
    logic [2:0] prev;
    int         w, idx, d;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'(exp_q.size()), 1);
      return;
    end
    e = exp_q.pop_front();
    d = e.d;
    check($sformatf("ovf_d%0d_v%0d", d, e.v), get_ovf(d), e.ovf);
    prev = get_sel(d);
    for (int k = 0; k < 2 * d; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (get_sel(d) == prev && w < 20);
      check("sel_changed", get_sel(d) != prev, 1);
      if (k > 0) check("slot_len", w, SD);
      prev = get_sel(d);
      check("sel_onehot", $onehot(prev), 1);
      idx = 0;
      for (int i = 0; i < 3; i++) if (prev[i]) idx = i;
      check($sformatf("seg_d%0d_v%0d_dig%0d", d, e.v, idx), get_seg(d), e.segs[7*idx +: 7]);
    end
  endtask

  // load v; optionally pulse a second value or assert reset on a given busy cycle
  task automatic load(input int d, input int v, input int inj_at, input int inj_v, input int rst_at);
    int n;
    exp_q.push_back(make_exp(d, (rst_at > 0) ? 0 : v));
    @(negedge clk);
    drive(d, 1'b1, v[7:0]);
    @(negedge clk);
    drive(d, 1'b0, v[7:0]);
    n = 0;
    while (get_busy(d) && n < 40) begin
      n++;
      if (n == inj_at) drive(d, 1'b1, inj_v[7:0]);
      if (n == rst_at) rst_n = 1'b0;
      @(negedge clk);
      drive(d, 1'b0, v[7:0]);
    end
    if (rst_at > 0) begin
      check("busy_after_rst", get_busy(d), 0);
      check("rst_busy_cycle", n, rst_at);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      check($sformatf("busy_len_d%0d_v%0d", d, v), n, 9);
    end
    scan_check();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    vld3  = 1'b0;
    vld2  = 1'b0;
    val3  = '0;
    val2  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy3, 0);
    check("rst_ovf", ovf3, 0);
    check("rst_sel", sel3, 3'b000);
    check("rst_seg", seg3, 7'b0000000);
    check("rst_sel_d2", sel2, 2'b00);
    rst_n = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (sel3 == 3'b000 && w < 20);
    check("first_tick_delay", w, SD);
    check("first_tick_sel", sel3, 3'b001);
    check("first_tick_seg", seg3, 7'b1111110);

    load(3, 123, 0, 0, 0);
    load(3, 7,   0, 0, 0);
    load(3, 0,   0, 0, 0);
    load(3, 255, 0, 0, 0);
    load(2, 100, 0, 0, 0);
    load(2, 99,  0, 0, 0);
    load(2, 5,   0, 0, 0);
    load(3, 45,  3, 200, 0);
    load(3, 45,  0, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dled_scan.md
Name: dled_scan

Overview:
- Parametrised multi-digit 7-segment scanner for the DL display path.
- Next generation of the 3-digit LED driver. Accepts a binary count from a controller, such as the traffic-light main module.
- Converts the count to BCD sequentially with shift-add-3. Latches the result atomically into a display buffer and time-multiplexes the digits.
- Adds leading-zero blanking, overflow indication, a load handshake and an internal scan prescaler.

Parameters:
- DIGITS, 3: number of digit positions; sel width.
- VAL_W, 8: input binary width.
- SCAN_DIV, 24000: clk cycles per digit slot (24 MHz -> 1 kHz slot rate).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- val  input  VAL_W  binary value to display
- val_vld  input  1  load strobe for val
- busy  output  1  conversion in progress; val_vld ignored while high
- ovf  output  1  displayed value is the overflow pattern
- sel  output  DIGITS  one-hot digit select; sel[0] = ones digit
- seg  output  7  {a,b,c,d,e,f,g}, active-high segments

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; all state is sampled at posedge clk.
- Reset values:
  - busy=0, ovf=0, sel=0, seg=0.
  - Display buffer = all-zero BCD; prescaler=0; digit index=DIGITS-1, so the first tick selects digit 0.
  - FSM=IDLE.
- FSM states:
  - IDLE: if val_vld, capture val into the shift register, clear the BCD accumulator and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: runs exactly VAL_W cycles. Each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1. After the VAL_W-th shift, go to COMMIT.
  - COMMIT: one cycle. Write the BCD result to the display buffer, update ovf, then go to IDLE with busy=0.
- Latency:
  - val_vld sampled at cycle t.
  - busy=1 during cycles t+1 .. t+VAL_W+1.
  - Buffer valid from t+VAL_W+2, so a back-to-back load is possible at t+VAL_W+2.
- val_vld while busy=1: ignored. No queueing; the in-flight conversion is unaffected.
- BCD accumulator width: 4*DIGITS bits.
  - Overflow is val >= 10^DIGITS, evaluated at capture and held with the conversion.
  - On COMMIT with overflow: ovf=1 and every digit displays "-" (seg=0000001).
  - On COMMIT without overflow: ovf=0.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps. On the terminal count, the digit index advances, wrapping DIGITS-1 -> 0.
  - sel and seg are registered and update on the same edge, so sel never changes without seg.
- Decode:
  - 0..9 to the standard table (0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011).
  - Nibbles 10..15 display 0000000.
- Leading-zero blanking:
  - A digit above the most significant nonzero digit shows seg=0000000; its sel is still driven.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Blanking does not apply when ovf=1.
- The display buffer changes only in COMMIT. The scan keeps running unaffected during conversion, showing the old value.
- Reset mid-conversion: abort, return to reset values; the buffer is cleared to 0.

Optional Feature:
- Macro: DLED_SCAN_BLINK_EN.
- When defined:
  - Adds input port blink (1 bit) and a blink phase bit that toggles every 256 complete scan cycles (256*DIGITS*SCAN_DIV clk). The phase resets to 0 (visible).
  - While blink=1 and phase=1, seg is forced to 0000000; sel still scans.
- When undefined: no blink port, no phase counter, and seg is never gated.

Test Plan:
- Use SCAN_DIV=4 throughout.
- Reset: hold rst_n=0 for 3 cycles -> busy=0, ovf=0, sel=000, seg=0000000; after release, first tick sel=001, seg=1111110.
- Load val=123 (DIGITS=3, VAL_W=8):
  - busy high for 9 cycles.
  - Then sel 001/010/100 -> seg 1111001/1101101/0110000, repeating every 12 clk.
- Load val=7:
  - sel=001 seg=1110000.
  - sel=010 and sel=100 -> seg=0000000 (blanked).
  - Load val=0 -> digit 0 shows 1111110.
- Overflow: DIGITS=2, VAL_W=8, load val=100 -> ovf=1, both digits 0000001; load val=99 -> ovf=0, digits 1111011/1111011.
- Handshake and mid-conversion reset:
  - Pulse val_vld with 45, then val_vld with 200 on the 3rd busy cycle -> display 45 only.
  - Repeat the 45 load, assert rst_n=0 on the 4th busy cycle -> busy=0, buffer=0, display "0".
- With DLED_SCAN_BLINK_EN, blink=1, val=5 -> seg=1011011 for 256 scan cycles, 0000000 for the next 256; blink=0 -> steady.
